// File: rtl/l2_port_arbiter.sv
// l2_port_arbiter: buffers per-L1 line requests in per-port FIFOs, grants one per
// cycle onto the single L2 request channel tagged {port, id}, and routes L2
// responses back to the originating L1 by that tag.
// Build option: define ARB_FIXED_PRIO_EN for strict lowest-port-first priority;
// left undefined, arbitration is round-robin.

// Per-port request FIFO; pointers carry a wrap bit so full/empty need no extra state.
module l2_port_fifo #(
  parameter int W  = 8,
  parameter int DL = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         empty,
  output logic         full
);
  localparam int D = 1 << DL;

  logic [DL:0]         wptr, rptr;
  logic [DL:0]         count;
  logic [D-1:0][W-1:0] mem;

  assign count = wptr - rptr;
  assign full  = (count == (DL+1)'(D));
  assign empty = (wptr == rptr);
  assign rdata = mem[rptr[DL-1:0]];

  // Storage needs no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wptr[DL-1:0]] <= wdata;
  end

  // Pointer advance; reset discards everything buffered.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end
endmodule

module l2_port_arbiter #(
  parameter int NUM_PORTS      = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int LINE_WIDTH     = 256,
  parameter int ID_BITS        = 3,
  parameter int FIFO_DEPTH_LOG = 2,
  localparam int PORT_BITS     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
  localparam int TAG_BITS      = ID_BITS + PORT_BITS
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_PORTS-1:0]            req_valid_i,
  input  logic [NUM_PORTS-1:0]            req_rw_i,
  input  logic [ADDR_WIDTH*NUM_PORTS-1:0] req_addr_i,
  input  logic [LINE_WIDTH*NUM_PORTS-1:0] req_data_i,
  input  logic [ID_BITS*NUM_PORTS-1:0]    req_id_i,
  output logic [NUM_PORTS-1:0]            req_stall_o,
  output logic                            l2_valid_o,
  output logic                            l2_rw_o,
  output logic [ADDR_WIDTH-1:0]           l2_addr_o,
  output logic [LINE_WIDTH-1:0]           l2_data_o,
  output logic [TAG_BITS-1:0]             l2_id_o,
  input  logic                            l2_stall_i,
  input  logic                            l2_rsp_valid_i,
  input  logic [LINE_WIDTH-1:0]           l2_rsp_data_i,
  input  logic [TAG_BITS-1:0]             l2_rsp_id_i,
  output logic [NUM_PORTS-1:0]            rsp_valid_o,
  output logic [LINE_WIDTH-1:0]           rsp_data_o,
  output logic [ID_BITS-1:0]              rsp_id_o
);
  typedef struct packed {
    logic                  rw;
    logic [ADDR_WIDTH-1:0] addr;
    logic [LINE_WIDTH-1:0] data;
    logic [ID_BITS-1:0]    id;
  } req_t;

  localparam int ENT_W = $bits(req_t);
  // One extra bit so rr_ptr+k (up to 2*NUM_PORTS-1) never overflows before the wrap.
  localparam int PB1   = PORT_BITS + 1;

  logic [NUM_PORTS-1:0][ENT_W-1:0] wdata, head;
  logic [NUM_PORTS-1:0]            push, pop, empty;
  logic [(1<<PB1)-1:0]             ne_pad;
  logic [PB1-1:0]                  cand;
  logic [PORT_BITS-1:0]            winner;
  logic                            grant_any, stage_free, grant;
  req_t                            head_req;
  logic [PORT_BITS-1:0]            rsp_port;
  logic [NUM_PORTS-1:0]            rsp_hot;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign push[p]  = req_valid_i[p] & ~req_stall_o[p];
    assign wdata[p] = {req_rw_i[p], req_addr_i[p*ADDR_WIDTH +: ADDR_WIDTH],
                       req_data_i[p*LINE_WIDTH +: LINE_WIDTH], req_id_i[p*ID_BITS +: ID_BITS]};
    l2_port_fifo #(.W(ENT_W), .DL(FIFO_DEPTH_LOG)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push[p]),
      .wdata (wdata[p]),
      .pop   (pop[p]),
      .rdata (head[p]),
      .empty (empty[p]),
      .full  (req_stall_o[p])
    );
  end

  // Zero-padded non-empty mask so the search index never goes out of range.
  assign ne_pad     = {{((1<<PB1)-NUM_PORTS){1'b0}}, ~empty};
  assign stage_free = ~l2_valid_o | ~l2_stall_i;
  assign grant      = stage_free & grant_any;
  assign head_req   = req_t'(head[winner]);

`ifdef ARB_FIXED_PRIO_EN
  // Strict priority: descending scan so the lowest non-empty port is written last.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = NUM_PORTS-1; k >= 0; k--) begin
      cand = PB1'(k);
      if (ne_pad[cand]) begin
        grant_any = 1'b1;
        winner    = cand[PORT_BITS-1:0];
      end
    end
  end
`else
  logic [PORT_BITS-1:0] rr_ptr;

  // Round-robin pointer follows the last winner; starts so port 0 wins first.
  always_ff @(posedge clk) begin
    if (reset)      rr_ptr <= PORT_BITS'(NUM_PORTS-1);
    else if (grant) rr_ptr <= winner;
  end

  // Search from rr_ptr+1; descending scan so the nearest candidate is written last.
  always_comb begin
    grant_any = 1'b0;
    winner    = '0;
    cand      = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      cand = {1'b0, rr_ptr} + PB1'(k);
      if (cand >= PB1'(NUM_PORTS)) cand = cand - PB1'(NUM_PORTS);
      if (ne_pad[cand]) begin
        grant_any = 1'b1;
        winner    = cand[PORT_BITS-1:0];
      end
    end
  end
`endif

  // Pop only the granted port.
  always_comb begin
    pop = '0;
    if (grant) pop[winner] = 1'b1;
  end

  // Registered L2 request stage; held bit-stable while L2 stalls a valid request.
  always_ff @(posedge clk) begin
    if (reset) begin
      l2_valid_o <= 1'b0;
      l2_rw_o    <= 1'b0;
      l2_addr_o  <= '0;
      l2_data_o  <= '0;
      l2_id_o    <= '0;
    end else if (stage_free) begin
      if (grant_any) begin
        l2_valid_o <= 1'b1;
        l2_rw_o    <= head_req.rw;
        l2_addr_o  <= head_req.addr;
        l2_data_o  <= head_req.data;
        l2_id_o    <= {winner, head_req.id};
      end else begin
        l2_valid_o <= 1'b0;
      end
    end
  end

  assign rsp_port = l2_rsp_id_i[TAG_BITS-1:ID_BITS];

  // One-hot decode of the response tag; out-of-range ports match nothing and drop.
  always_comb begin
    rsp_hot = '0;
    for (int k = 0; k < NUM_PORTS; k++)
      rsp_hot[k] = l2_rsp_valid_i & (rsp_port == PORT_BITS'(k));
  end

  // Response register: valid pulses for one cycle, data/id hold the last delivery.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_o <= '0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
    end else begin
      rsp_valid_o <= rsp_hot;
      if (|rsp_hot) begin
        rsp_data_o <= l2_rsp_data_i;
        rsp_id_o   <= l2_rsp_id_i[ID_BITS-1:0];
      end
    end
  end
endmodule
